// File: rtl/sram_pkg.sv
// Shared constants and types for the burst SRAM controller: state encoding,
// default memory map and bus width.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEFAULT_BASE_ADDR = 1024;
  localparam int DEFAULT_SRAM_AW   = 18;
  localparam int BUS_W             = 16;

  // Counter width that stays at least one bit for a range of a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_beat_counter.sv
// Nested wait/beat counters for one burst; both clear whenever en is low so
// every access starts at beat 0, wait 0.
module sram_beat_counter
  import sram_pkg::*;
#(
  parameter int WORD_BEATS  = 2,
  parameter int WAIT_CYCLES = 1,
  localparam int BW = cnt_width(WORD_BEATS),
  localparam int WW = cnt_width(WAIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [BW-1:0] beat,
  output logic          last_wait,
  output logic          last_beat
);

  logic [WW-1:0] wait_cnt;

  assign last_wait = (wait_cnt == WW'(WAIT_CYCLES - 1));
  assign last_beat = (beat == BW'(WORD_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (!en) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (last_wait) begin
      wait_cnt <= '0;
      beat     <= last_beat ? '0 : beat + 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// MEM-stage to 16-bit async SRAM bridge: one request becomes WORD_BEATS
// consecutive beats, each held WAIT_CYCLES cycles on the bus.
module sram_burst_ctrl
  import sram_pkg::*;
#(
  parameter int WORD_BEATS  = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int SRAM_AW     = DEFAULT_SRAM_AW,
  localparam int DW = BUS_W * WORD_BEATS,
  localparam int BW = cnt_width(WORD_BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEnIn,
  input  logic               rdEnIn,
  input  logic [31:0]        addressIn,
  input  logic [DW-1:0]      writeDataIn,
  output logic [DW-1:0]      readDataOut,
  output logic               readyOut,
  inout  wire  [BUS_W-1:0]   SRAM_DQInOut,
  output logic [SRAM_AW-1:0] SRAM_ADDROut,
  output logic               SRAM_UB_NOut,
  output logic               SRAM_LB_NOut,
  output logic               SRAM_WE_NOut,
  output logic               SRAM_CE_NOut,
  output logic               SRAM_OE_NOut
);

  state_t state, state_next;

  logic               req;
  logic               op_rd;
  logic [SRAM_AW-1:0] base_q;
  logic [DW-1:0]      data_q;
  logic [BW-1:0]      beat;
  logic               last_wait;
  logic               last_beat;
  logic               in_access;
  logic               drive_dq;
  logic [31:0]        mem_addr;
  logic [31:0]        word_addr;
  logic [BUS_W-1:0]   wr_slice;

  assign req       = rdEnIn | wrEnIn;
  assign in_access = (state == ST_ACCESS);

  // Burst base is aligned down to a whole word; unaligned addresses round down.
  assign mem_addr  = addressIn - 32'(BASE_ADDR);
  assign word_addr = (mem_addr >> 1) & ~32'(WORD_BEATS - 1);

  sram_beat_counter #(
    .WORD_BEATS (WORD_BEATS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (in_access),
    .beat     (beat),
    .last_wait(last_wait),
    .last_beat(last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req) state_next = ST_ACCESS;
      ST_ACCESS: if (last_wait && last_beat) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    readyOut     = 1'b0;
    SRAM_CE_NOut = 1'b1;
    SRAM_OE_NOut = 1'b1;
    SRAM_WE_NOut = 1'b1;
    drive_dq     = 1'b0;
    case (state)
      ST_IDLE: readyOut = ~req;
      ST_ACCESS: begin
        SRAM_CE_NOut = 1'b0;
        if (op_rd) begin
          SRAM_OE_NOut = 1'b0;
        end else begin
          drive_dq = 1'b1;
          // Last wait cycle of a beat releases WE_N for address/data hold.
          SRAM_WE_NOut = (WAIT_CYCLES > 1) && last_wait;
        end
      end
      ST_DONE: readyOut = 1'b1;
      default: readyOut = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rd  <= 1'b0;
      base_q <= '0;
      data_q <= '0;
    end else if (state == ST_IDLE && req) begin
      op_rd  <= rdEnIn;
      base_q <= SRAM_AW'(word_addr);
      data_q <= writeDataIn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readDataOut <= '0;
    end else if (in_access && op_rd && last_wait) begin
      readDataOut[beat*BUS_W +: BUS_W] <= SRAM_DQInOut;
    end
  end

  assign wr_slice     = data_q[beat*BUS_W +: BUS_W];
  assign SRAM_DQInOut = drive_dq ? wr_slice : {BUS_W{1'bz}};
  assign SRAM_ADDROut = base_q + SRAM_AW'(beat);
  assign SRAM_UB_NOut = 1'b0;
  assign SRAM_LB_NOut = 1'b0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench: three controller configurations, each with a small SRAM model.
module tb_sram_burst_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]        rd_en, wr_en;
  logic [2:0][31:0]  addr;
  logic [2:0][63:0]  wdata;
  logic [31:0]       rdata0, rdata1;
  logic [63:0]       rdata2;
  logic [2:0]        ready, we_n, ce_n, oe_n, ub_n, lb_n;
  logic [17:0]       sa0, sa1, sa2;
  wire  [15:0]       dq0, dq1, dq2;
  logic [15:0]       mem0 [256];
  logic [15:0]       mem1 [256];
  logic [15:0]       mem2 [256];

  int checks = 0;
  int errors = 0;

  sram_burst_ctrl dut0 (
    .clk(clk), .rst(rst), .wrEnIn(wr_en[0]), .rdEnIn(rd_en[0]),
    .addressIn(addr[0]), .writeDataIn(wdata[0][31:0]), .readDataOut(rdata0),
    .readyOut(ready[0]), .SRAM_DQInOut(dq0), .SRAM_ADDROut(sa0),
    .SRAM_UB_NOut(ub_n[0]), .SRAM_LB_NOut(lb_n[0]), .SRAM_WE_NOut(we_n[0]),
    .SRAM_CE_NOut(ce_n[0]), .SRAM_OE_NOut(oe_n[0]));

  sram_burst_ctrl #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .wrEnIn(wr_en[1]), .rdEnIn(rd_en[1]),
    .addressIn(addr[1]), .writeDataIn(wdata[1][31:0]), .readDataOut(rdata1),
    .readyOut(ready[1]), .SRAM_DQInOut(dq1), .SRAM_ADDROut(sa1),
    .SRAM_UB_NOut(ub_n[1]), .SRAM_LB_NOut(lb_n[1]), .SRAM_WE_NOut(we_n[1]),
    .SRAM_CE_NOut(ce_n[1]), .SRAM_OE_NOut(oe_n[1]));

  sram_burst_ctrl #(.WORD_BEATS(4)) dut2 (
    .clk(clk), .rst(rst), .wrEnIn(wr_en[2]), .rdEnIn(rd_en[2]),
    .addressIn(addr[2]), .writeDataIn(wdata[2]), .readDataOut(rdata2),
    .readyOut(ready[2]), .SRAM_DQInOut(dq2), .SRAM_ADDROut(sa2),
    .SRAM_UB_NOut(ub_n[2]), .SRAM_LB_NOut(lb_n[2]), .SRAM_WE_NOut(we_n[2]),
    .SRAM_CE_NOut(ce_n[2]), .SRAM_OE_NOut(oe_n[2]));

  // Async SRAM models: drive on read, capture while WE_N is low.
  assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem0[sa0[7:0]] : 16'hzzzz;
  assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem1[sa1[7:0]] : 16'hzzzz;
  assign dq2 = (!ce_n[2] && !oe_n[2] && we_n[2]) ? mem2[sa2[7:0]] : 16'hzzzz;

  always @(posedge clk) if (!ce_n[0] && !we_n[0]) mem0[sa0[7:0]] <= dq0;
  always @(posedge clk) if (!ce_n[1] && !we_n[1]) mem1[sa1[7:0]] <= dq1;
  always @(posedge clk) if (!ce_n[2] && !we_n[2]) mem2[sa2[7:0]] <= dq2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] get_rdata(input int inst);
    case (inst)
      0: return {32'h0, rdata0};
      1: return {32'h0, rdata1};
      default: return rdata2;
    endcase
  endfunction

  function automatic logic [15:0] peek(input int inst, input int idx);
    case (inst)
      0: return mem0[idx];
      1: return mem1[idx];
      default: return mem2[idx];
    endcase
  endfunction

  // One request held until readyOut; reports cycle of first ready and strobe activity.
  task automatic access(input int inst, input bit r, input bit w,
                        input logic [31:0] a, input logic [63:0] d,
                        output int cycles, output int we_low, output int ce_low,
                        output logic [15:0] hist);
    bit done = 0;
    cycles = 0; we_low = 0; ce_low = 0; hist = '0;
    @(negedge clk);
    rd_en[inst] = r; wr_en[inst] = w; addr[inst] = a; wdata[inst] = d;
    while (!done && cycles < 64) begin
      @(negedge clk);
      cycles++;
      if (cycles <= 16) hist[cycles-1] = we_n[inst];
      if (!we_n[inst]) we_low++;
      if (!ce_n[inst]) ce_low++;
      if (ready[inst]) done = 1;
    end
    rd_en[inst] = 1'b0; wr_en[inst] = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout inst %0d: no readyOut within %0d cycles", inst, cycles);
    end
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [63:0] d;
    int          widx;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic [63:0] exp_rd;
    int          exp_we;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc, wl, cl;
    logic [15:0] h;

    vecs[0] = '{1'b0, 1'b1, 32'd1028, 64'hDEADBEEF, 2,    16'hBEEF, 16'hDEAD, 64'h0,        2};
    vecs[1] = '{1'b1, 1'b0, 32'd1030, 64'h0,        2,    16'hBEEF, 16'hDEAD, 64'hDEADBEEF, 0};
    vecs[2] = '{1'b0, 1'b1, 32'd1033, 64'h12345678, 4,    16'h5678, 16'h1234, 64'hDEADBEEF, 2};
    vecs[3] = '{1'b1, 1'b1, 32'd1033, 64'hFFFFFFFF, 4,    16'h5678, 16'h1234, 64'h12345678, 0};
    vecs[4] = '{1'b0, 1'b1, 32'd1024, 64'hCAFEF00D, 0,    16'hF00D, 16'hCAFE, 64'h12345678, 2};
    vecs[5] = '{1'b1, 1'b0, 32'd1026, 64'h0,        0,    16'hF00D, 16'hCAFE, 64'hCAFEF00D, 0};
    vecs[6] = '{1'b0, 1'b1, 32'd1020, 64'hA5A55A5A, 8'hFE, 16'h5A5A, 16'hA5A5, 64'hCAFEF00D, 2};
    vecs[7] = '{1'b1, 1'b0, 32'd1020, 64'h0,        8'hFE, 16'h5A5A, 16'hA5A5, 64'hA5A55A5A, 0};

    rst = 1'b1;
    rd_en = '0; wr_en = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset ready",  {61'h0, ready}, 64'h7);
    check("reset ce_n",   {61'h0, ce_n},  64'h7);
    check("reset we_n",   {61'h0, we_n},  64'h7);
    check("reset oe_n",   {61'h0, oe_n},  64'h7);
    check("reset ub_lb",  {58'h0, ub_n, lb_n}, 64'h0);
    check("reset addr",   {46'h0, sa0},   64'h0);
    check("reset rdata",  get_rdata(0),   64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      access(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, cyc, wl, cl, h);
      check($sformatf("vec%0d ready cycle", i), 64'(cyc), 64'd3);
      check($sformatf("vec%0d we_low", i),      64'(wl),  64'(vecs[i].exp_we));
      check($sformatf("vec%0d ce_low", i),      64'(cl),  64'd2);
      check($sformatf("vec%0d mem lo", i), {48'h0, peek(0, vecs[i].widx)},   {48'h0, vecs[i].exp_lo});
      check($sformatf("vec%0d mem hi", i), {48'h0, peek(0, vecs[i].widx+1)}, {48'h0, vecs[i].exp_hi});
      check($sformatf("vec%0d rdata", i),  get_rdata(0), vecs[i].exp_rd);
    end
    check("idle after access ready", {63'h0, ready[0]}, 64'h1);

    // WAIT_CYCLES=3: WE_N pattern per cycle 1..7 is 0,0,1,0,0,1,1
    access(1, 1'b0, 1'b1, 32'd1032, 64'h11112222, cyc, wl, cl, h);
    check("wait3 write ready cycle", 64'(cyc), 64'd7);
    check("wait3 we pattern", {48'h0, h}, 64'h0064);
    check("wait3 ce_low", 64'(cl), 64'd6);
    check("wait3 mem lo", {48'h0, peek(1, 4)}, 64'h2222);
    check("wait3 mem hi", {48'h0, peek(1, 5)}, 64'h1111);
    access(1, 1'b1, 1'b0, 32'd1034, 64'h0, cyc, wl, cl, h);
    check("wait3 read ready cycle", 64'(cyc), 64'd7);
    check("wait3 read we_low", 64'(wl), 64'd0);
    check("wait3 rdata", get_rdata(1), 64'h11112222);

    // WORD_BEATS=4 burst
    access(2, 1'b0, 1'b1, 32'd1040, 64'h0123_4567_89AB_CDEF, cyc, wl, cl, h);
    check("beats4 write ready cycle", 64'(cyc), 64'd5);
    check("beats4 we_low", 64'(wl), 64'd4);
    check("beats4 mem8",  {48'h0, peek(2, 8)},  64'hCDEF);
    check("beats4 mem9",  {48'h0, peek(2, 9)},  64'h89AB);
    check("beats4 mem10", {48'h0, peek(2, 10)}, 64'h4567);
    check("beats4 mem11", {48'h0, peek(2, 11)}, 64'h0123);
    access(2, 1'b1, 1'b0, 32'd1046, 64'h0, cyc, wl, cl, h);
    check("beats4 read ready cycle", 64'(cyc), 64'd5);
    check("beats4 rdata", get_rdata(2), 64'h0123_4567_89AB_CDEF);

    // Reset during beat 1 of a write
    @(negedge clk);
    wr_en[0] = 1'b1; addr[0] = 32'd1036; wdata[0] = 64'h55556666;
    @(negedge clk);
    check("midrst beat0 ce_n", {63'h0, ce_n[0]}, 64'h0);
    @(negedge clk);
    check("midrst beat1 addr", {46'h0, sa0}, 64'd7);
    rst = 1'b1;
    #1;
    check("midrst ce_n", {63'h0, ce_n[0]}, 64'h1);
    check("midrst we_n", {63'h0, we_n[0]}, 64'h1);
    check("midrst oe_n", {63'h0, oe_n[0]}, 64'h1);
    check("midrst addr", {46'h0, sa0}, 64'h0);
    check("midrst rdata", get_rdata(0), 64'h0);
    check("midrst ready held req", {63'h0, ready[0]}, 64'h0);
    wr_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst partial word6", {48'h0, peek(0, 6)}, 64'h6666);
    access(0, 1'b0, 1'b1, 32'd1036, 64'h77778888, cyc, wl, cl, h);
    check("post-rst ready cycle", 64'(cyc), 64'd3);
    check("post-rst word6", {48'h0, peek(0, 6)}, 64'h8888);
    check("post-rst word7", {48'h0, peek(0, 7)}, 64'h7777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
